uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
- Sequences one UART transmit frame per accepted byte: start bit, data bits LSB-first, optional parity, stop bit(s).
- Runs off the one-cycle 16x oversample tick from the baud rate generator and owns that generator's enable, so the generator only runs while a frame is in flight.
- Sits between the byte-producing logic (host FSM or FIFO) and the serial TX pin.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)
OVERSAMPLE, 16, ticks per bit; power of two

Ports:
clock  input  1  system clock; all logic on the rising edge
Reset  input  1  asynchronous, active-low reset
uartClock  input  1  oversample tick from the baud rate generator; one clock wide
BaudEnable  output  1  enable for the baud rate generator
TxData  input  DATA_BITS  byte to transmit
TxStart  input  1  request; the byte is accepted when TxStart and TxReady are both 1
TxReady  output  1  sequencer idle and able to accept a byte
TxBusy  output  1  frame in progress
TxDone  output  1  one-cycle pulse at the end of the last stop bit
TxSerial  output  1  serial line; idles high

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - state=IDLE, TxSerial=1, TxReady=1, TxBusy=0, TxDone=0, BaudEnable=0.
  - Shift register, tick counter and bit counter all cleared.
  - Reset mid-frame aborts the frame immediately; TxSerial returns high with no glitch low.
- All outputs are registered.
- IDLE:
  - TxReady=1, TxSerial=1, BaudEnable=0.
  - On TxStart=1: latch TxData into the shift register, clear parity accumulator, tick_cnt and bit_cnt, go to START.
  - In the cycle after acceptance: TxReady=0, TxBusy=1, BaudEnable=1, TxSerial=0.
  - TxStart while not in IDLE is ignored; no queueing.
- Bit timing (every non-IDLE state):
  - tick_cnt (log2(OVERSAMPLE) bits) increments on each uartClock=1.
  - A bit ends on the uartClock pulse where tick_cnt == OVERSAMPLE-1; tick_cnt wraps to 0 on that pulse.
  - Cycles without uartClock hold all state.
  - Because the generator phase is free-running, the start bit may be up to one tick period short; every later bit is exactly OVERSAMPLE ticks.
- START: TxSerial=0. At bit end go to DATA and drive shift_reg[0].
- DATA:
  - TxSerial = shift_reg[0].
  - At each bit end: shift right, XOR the outgoing bit into parity, increment bit_cnt.
  - When bit_cnt == DATA_BITS-1 at bit end: go to PARITY if PARITY_EN, else STOP.
- PARITY: TxSerial = parity_acc XOR PARITY_ODD. At bit end go to STOP.
- STOP:
  - TxSerial=1 for STOP_BITS bit periods (a stop counter is reused).
  - At the final bit end: go to IDLE, pulse TxDone=1 for one cycle, drop BaudEnable and TxBusy.
  - TxReady=1 from the next cycle.
- Back-to-back frames:
  - Earliest next acceptance is the cycle TxReady=1, i.e. one clock after TxDone.
  - A byte accepted then starts a new START with no extra idle bit.
- Frame length in ticks: OVERSAMPLE*(1 + DATA_BITS + PARITY_EN + STOP_BITS), start-bit shortfall excepted.
- The generator divisor is not touched by this block. BaudEnable=0 freezes the generator count but does not clear it.

Test Plan:
- Reset mid-frame: Reset=0 during DATA bit 3 -> TxSerial=1, TxBusy=0, TxReady=1, BaudEnable=0 in the same cycle. After release, a new TxStart transmits a correct frame.
- Basic frame: DATA_BITS=8, no parity, 1 stop, uartClock pulsed every 4 clocks, TxData=8'hA5 -> line sequence 0,1,0,1,0,0,1,0,1,1.
  - Each bit after the start bit holds 64 clocks.
  - TxDone pulses once; TxReady returns one cycle later.
- Parity: PARITY_EN=1, PARITY_ODD=0, TxData=8'h07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0.
- Two stop bits: STOP_BITS=2, TxData=8'hFF -> line high for 32 ticks after the data bits before TxDone.
- Handshake: hold TxStart=1 continuously with TxData changing mid-frame -> the frame carries the byte latched at acceptance.
  - Second frame starts exactly one cycle after TxDone.
  - No acceptance occurs while TxBusy=1.
- Tick gaps: uartClock with irregular spacing (gaps of 1..7 clocks) -> bit boundaries occur only on the 16th tick. State holds between ticks; BaudEnable=1 throughout the frame and 0 in IDLE.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity, stop bit(s).
// Paced by the 16x oversample tick; gates the baud generator so it only runs mid-frame.
module uart_tx_sequencer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 Reset,
    input  logic                 uartClock,
    output logic                 BaudEnable,
    input  logic [DATA_BITS-1:0] TxData,
    input  logic                 TxStart,
    output logic                 TxReady,
    output logic                 TxBusy,
    output logic                 TxDone,
    output logic                 TxSerial
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned CNT_W  = 3;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [CNT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  serial_q, serial_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  baud_q, baud_d;
    logic                  bit_end_c;

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            baud_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            baud_q   <= baud_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        done_d    = 1'b0;
        bit_end_c = 1'b0;

        // Ticks are only counted mid-frame; a bit closes on the last tick of its period
        if ((state_q != S_IDLE) && uartClock) begin
            bit_end_c = (tick_q == TICK_LAST);
            tick_d    = bit_end_c ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (TxStart && ready_q) begin
                    shift_d = TxData;
                    par_d   = 1'b0;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[0];
            S_PARITY: serial_d = par_d ^ PAR_ODD;
            default:  serial_d = 1'b1;
        endcase

        // Ready lags the done pulse by one cycle, so no byte is taken on the done cycle
        busy_d  = (state_d != S_IDLE);
        baud_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE) && !done_d;
    end

    assign TxSerial   = serial_q;
    assign TxReady    = ready_q;
    assign TxBusy     = busy_q;
    assign TxDone     = done_q;
    assign BaudEnable = baud_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: three parameter sets driven in lockstep,
// line sampled mid-bit by tick count, expected frames built from hand-derived tables.
module tb_uart_tx_sequencer;

    localparam int unsigned NI = 3;

    logic          clock = 1'b0;
    logic          Reset;
    logic          uartClock;
    logic [7:0]    tx_data;
    logic [NI-1:0] start;
    logic [NI-1:0] baud, ready, busy, done, serial;

    int n_tests   = 0;
    int n_fail    = 0;
    int irregular = 0;
    int gaps [8]  = '{2, 5, 3, 8, 4, 6, 2, 7};

    logic [11:0] cap [NI];
    int          done_tick [NI];
    int          hold_bad [NI];
    int          run_bad [NI];
    int          span_a;

    always #5 clock = ~clock;

    // 8N1
    uart_tx_sequencer dut_a (
        .clock(clock), .Reset(Reset), .uartClock(uartClock), .BaudEnable(baud[0]),
        .TxData(tx_data), .TxStart(start[0]), .TxReady(ready[0]), .TxBusy(busy[0]),
        .TxDone(done[0]), .TxSerial(serial[0]));
    // 8E2
    uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clock(clock), .Reset(Reset), .uartClock(uartClock), .BaudEnable(baud[1]),
        .TxData(tx_data), .TxStart(start[1]), .TxReady(ready[1]), .TxBusy(busy[1]),
        .TxDone(done[1]), .TxSerial(serial[1]));
    // 8O1
    uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_c (
        .clock(clock), .Reset(Reset), .uartClock(uartClock), .BaudEnable(baud[2]),
        .TxData(tx_data), .TxStart(start[2]), .TxReady(ready[2]), .TxBusy(busy[2]),
        .TxDone(done[2]), .TxSerial(serial[2]));

    // One-clock oversample tick, spaced 4 clocks or by the irregular gap table
    initial begin : tick_gen
        int gi;
        int p;
        gi = 0;
        uartClock = 1'b0;
        forever begin
            @(posedge clock); #2 uartClock = 1'b1;
            @(posedge clock); #2 uartClock = 1'b0;
            p = (irregular != 0) ? gaps[gi % 8] : 4;
            gi++;
            repeat (p - 2) @(posedge clock);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [7:0] d, input logic [NI-1:0] en, input logic hold);
        @(posedge clock); #2 tx_data = d; start = en;
        @(posedge clock); #2 if (!hold) start = '0;
    endtask

    // Follows a frame from the acceptance edge, sampling each bit at its 8th tick
    task automatic capture(input logic [NI-1:0] en, input int abort_at,
                           input int swap_at, input logic [7:0] swap_data);
        int n;
        int cyc;
        int c16;
        logic pend;
        logic tick;
        logic [NI-1:0] prev;
        logic [NI-1:0] fin;
        n = 0; cyc = 0; c16 = 0; fin = '0; span_a = 0;
        for (int i = 0; i < NI; i++) begin
            cap[i] = '0; done_tick[i] = -1; hold_bad[i] = 0; run_bad[i] = 0;
        end
        @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            if (en[i]) begin
                check($sformatf("acc_serial%0d", i), 32'(serial[i]), 32'd0);
                check($sformatf("acc_busy%0d", i), 32'(busy[i]), 32'd1);
                check($sformatf("acc_ready%0d", i), 32'(ready[i]), 32'd0);
                check($sformatf("acc_baud%0d", i), 32'(baud[i]), 32'd1);
            end
        end
        prev = serial;
        pend = uartClock;
        while (fin != en && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            tick = pend;
            if (tick) n++;
            if (tick && n == 16) c16 = cyc;
            for (int i = 0; i < NI; i++) begin
                if (en[i] && !fin[i]) begin
                    if (done_tick[i] >= 0) begin
                        check($sformatf("post_ready%0d", i), 32'(ready[i]), 32'd1);
                        check($sformatf("post_busy%0d", i), 32'(busy[i]), 32'd0);
                        check($sformatf("post_done%0d", i), 32'(done[i]), 32'd0);
                        fin[i] = 1'b1;
                    end else if (done[i]) begin
                        done_tick[i] = n;
                        check($sformatf("done_ready%0d", i), 32'(ready[i]), 32'd0);
                        check($sformatf("done_busy%0d", i), 32'(busy[i]), 32'd0);
                        check($sformatf("done_baud%0d", i), 32'(baud[i]), 32'd0);
                        check($sformatf("done_serial%0d", i), 32'(serial[i]), 32'd1);
                        if (i == 0) span_a = cyc - c16;
                    end else begin
                        if (serial[i] != prev[i] && !tick) hold_bad[i]++;
                        if (!baud[i] || !busy[i] || ready[i]) run_bad[i]++;
                        if (tick && (n % 16) == 8 && n < 192) cap[i][n / 16] = serial[i];
                    end
                end
            end
            if (swap_at > 0 && n == swap_at) tx_data = swap_data;
            if (abort_at > 0 && n == abort_at) begin
                Reset = 1'b0;
                #1;
                for (int i = 0; i < NI; i++) begin
                    if (en[i]) begin
                        check($sformatf("rst_serial%0d", i), 32'(serial[i]), 32'd1);
                        check($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
                        check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
                        check($sformatf("rst_baud%0d", i), 32'(baud[i]), 32'd0);
                    end
                end
                fin = en;
            end
            prev = serial;
            pend = uartClock;
        end
        check("frame_end", 32'(fin), 32'(en));
    endtask

    // Frame layout {stop(s), parity, data, start}; pe is the hand-counted even parity
    task automatic check_frames(input logic [7:0] d, input logic pe, input logic [NI-1:0] en,
                                input logic regular);
        if (en[0]) begin
            check("frame_8n1", 32'(cap[0][9:0]), 32'({1'b1, d, 1'b0}));
            check("done_tick_8n1", 32'(done_tick[0]), 32'd160);
            check("hold_8n1", 32'(hold_bad[0]), 32'd0);
            check("run_8n1", 32'(run_bad[0]), 32'd0);
            if (regular) check("span_8n1", 32'(span_a), 32'd576);
        end
        if (en[1]) begin
            check("frame_8e2", 32'(cap[1]), 32'({2'b11, pe, d, 1'b0}));
            check("done_tick_8e2", 32'(done_tick[1]), 32'd192);
            check("hold_8e2", 32'(hold_bad[1]), 32'd0);
            check("run_8e2", 32'(run_bad[1]), 32'd0);
        end
        if (en[2]) begin
            check("frame_8o1", 32'(cap[2][10:0]), 32'({1'b1, ~pe, d, 1'b0}));
            check("done_tick_8o1", 32'(done_tick[2]), 32'd176);
            check("hold_8o1", 32'(hold_bad[2]), 32'd0);
            check("run_8o1", 32'(run_bad[2]), 32'd0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] vd [5];
        logic       vp [5];
        vd = '{8'hA5, 8'h07, 8'hFF, 8'h80, 8'h00};
        vp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        Reset   = 1'b0;
        start   = '0;
        tx_data = '0;

        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_serial%0d", i), 32'(serial[i]), 32'd1);
            check($sformatf("reset_ready%0d", i), 32'(ready[i]), 32'd1);
            check($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("reset_done%0d", i), 32'(done[i]), 32'd0);
            check($sformatf("reset_baud%0d", i), 32'(baud[i]), 32'd0);
        end
        @(posedge clock); #2 Reset = 1'b1;
        repeat (5) @(posedge clock);

        for (int v = 0; v < 5; v++) begin
            launch(vd[v], 3'b111, 1'b0);
            capture(3'b111, 0, 0, 8'h00);
            check_frames(vd[v], vp[v], 3'b111, 1'b1);
        end

        // Irregular tick spacing
        irregular = 1;
        launch(8'h96, 3'b111, 1'b0);
        capture(3'b111, 0, 0, 8'h00);
        check_frames(8'h96, 1'b0, 3'b111, 1'b0);
        irregular = 0;

        // Start held high with data changing mid-frame, then an immediate second frame
        launch(8'h3C, 3'b001, 1'b1);
        capture(3'b001, 0, 40, 8'hC3);
        check_frames(8'h3C, 1'b0, 3'b001, 1'b1);
        capture(3'b001, 0, 0, 8'h00);
        start = '0;
        check_frames(8'hC3, 1'b0, 3'b001, 1'b1);

        // Reset asserted during data bit 3, then a clean frame
        repeat (3) @(posedge clock);
        launch(8'hA5, 3'b111, 1'b0);
        capture(3'b111, 72, 0, 8'h00);
        @(posedge clock); #2 Reset = 1'b1;
        repeat (3) @(posedge clock);
        launch(8'h07, 3'b111, 1'b0);
        capture(3'b111, 0, 0, 8'h00);
        check_frames(8'h07, 1'b1, 3'b111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
